// File: rtl/pipe_skid_buf_pkg.sv
// Shared types and defaults for the fetch-side skid buffer.
package pipe_skid_buf_pkg;

  // Buffer fill level; the encoding doubles as the occupancy count.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam int DEF_PC_W    = 32;
  localparam int DEF_INSTR_W = 32;

  // Instruction presented on the output while nothing is buffered.
  localparam logic [DEF_INSTR_W-1:0] DEF_NOP_INSTR = '0;

endpackage

// File: rtl/pipe_entry_reg.sv
// One buffered entry: load-enabled register, async reset, edge selectable.
module pipe_entry_reg #(
  parameter int W        = 65,
  parameter int NEG_EDGE = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  generate
    if (NEG_EDGE != 0) begin : g_neg
      // Capture the entry on the falling edge when loaded.
      always_ff @(negedge clk or posedge rst) begin
        if (rst)       q <= '0;
        else if (load) q <= d;
      end
    end else begin : g_pos
      // Capture the entry on the rising edge when loaded.
      always_ff @(posedge clk or posedge rst) begin
        if (rst)       q <= '0;
        else if (load) q <= d;
      end
    end
  endgenerate

endmodule

// File: rtl/pipe_skid_buf.sv
// Two-entry in-order skid buffer between fetch and decode, with flush and
// sticky interrupt tracking so no interrupt request is ever dropped.
module pipe_skid_buf
  import pipe_skid_buf_pkg::*;
#(
  parameter int                 PC_W      = DEF_PC_W,
  parameter int                 INSTR_W   = DEF_INSTR_W,
  parameter int                 NEG_EDGE  = 1,
  parameter logic [INSTR_W-1:0] NOP_INSTR = INSTR_W'(DEF_NOP_INSTR)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [PC_W-1:0]    in_pc,
  input  logic [INSTR_W-1:0] in_instruction,
  input  logic               in_INT,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [PC_W-1:0]    out_pc,
  output logic [INSTR_W-1:0] out_instruction,
  output logic               out_INT,
  output logic [1:0]         occupancy
);

  // Entry layout: {int_flag, pc, instruction}.
  localparam int ENT_W = PC_W + INSTR_W + 1;

  state_t           state, state_nxt;
  logic             pend_int, pend_int_nxt;
  logic             push, pop;
  logic             ld_head, ld_tail;
  logic [ENT_W-1:0] in_ent, head_d, head_q, tail_q;

  // Ready depends only on fill level and reset, never on out_ready.
  assign in_ready = (state != FULL) && !rst;
  assign push     = in_valid && in_ready;
  assign pop      = out_valid && out_ready;
  assign in_ent   = {in_INT | pend_int, in_pc, in_instruction};

  // Next fill level, entry loads and sticky interrupt tracking.
  always_comb begin
    state_nxt    = state;
    pend_int_nxt = pend_int;
    ld_head      = 1'b0;
    ld_tail      = 1'b0;
    head_d       = in_ent;
    if (flush) begin
      // Kill everything, but keep any interrupt that rode on a killed entry.
      state_nxt    = EMPTY;
      pend_int_nxt = pend_int | in_INT
                   | ((state != EMPTY) && head_q[ENT_W-1])
                   | ((state == FULL)  && tail_q[ENT_W-1]);
    end else begin
      if (push)        pend_int_nxt = 1'b0;
      else if (in_INT) pend_int_nxt = 1'b1;
      unique case (state)
        EMPTY: begin
          if (push) begin
            state_nxt = ONE;
            ld_head   = 1'b1;
          end
        end
        ONE: begin
          if (push && pop) begin
            ld_head = 1'b1;
          end else if (push) begin
            state_nxt = FULL;
            ld_tail   = 1'b1;
          end else if (pop) begin
            state_nxt = EMPTY;
          end
        end
        FULL: begin
          // in_ready is low here, so only a pop can move things.
          if (pop) begin
            state_nxt = ONE;
            ld_head   = 1'b1;
            head_d    = tail_q;
          end
        end
        default: state_nxt = EMPTY;
      endcase
    end
  end

  generate
    if (NEG_EDGE != 0) begin : g_neg
      // Fill level and pending interrupt advance on the falling edge.
      always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
          state    <= EMPTY;
          pend_int <= 1'b0;
        end else begin
          state    <= state_nxt;
          pend_int <= pend_int_nxt;
        end
      end
    end else begin : g_pos
      // Fill level and pending interrupt advance on the rising edge.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state    <= EMPTY;
          pend_int <= 1'b0;
        end else begin
          state    <= state_nxt;
          pend_int <= pend_int_nxt;
        end
      end
    end
  endgenerate

  pipe_entry_reg #(.W(ENT_W), .NEG_EDGE(NEG_EDGE)) u_head (
    .clk  (clk),
    .rst  (rst),
    .load (ld_head),
    .d    (head_d),
    .q    (head_q)
  );

  pipe_entry_reg #(.W(ENT_W), .NEG_EDGE(NEG_EDGE)) u_tail (
    .clk  (clk),
    .rst  (rst),
    .load (ld_tail),
    .d    (in_ent),
    .q    (tail_q)
  );

  // Head is presented only when valid; otherwise a clean NOP bubble.
  assign out_valid       = (state != EMPTY);
  assign out_pc          = out_valid ? head_q[ENT_W-2:INSTR_W] : '0;
  assign out_instruction = out_valid ? head_q[INSTR_W-1:0] : NOP_INSTR;
  assign out_INT         = out_valid && head_q[ENT_W-1];
  assign occupancy       = state;

endmodule

// File: doc/pipe_skid_buf.md
PIPE_SKID_BUF -- requirements
Module: pipe_skid_buf

Interface
REQ-001 Parameter PC_W, default 32, width of the PC field.
REQ-002 Parameter INSTR_W, default 32, width of the instruction field.
REQ-003 Parameter NEG_EDGE, default 1: 1 = all state updates on falling clk edge, 0 = rising edge.
REQ-004 Parameter NOP_INSTR, default 0 (INSTR_W bits), instruction value presented when empty.
REQ-005 clk  in  1  single clock, active edge per NEG_EDGE.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 in_valid  in  1  upstream entry present.
REQ-008 in_ready  out  1  buffer accepts entry this cycle.
REQ-009 in_pc  in  PC_W  upstream PC.
REQ-010 in_instruction  in  INSTR_W  upstream instruction.
REQ-011 in_INT  in  1  interrupt request from upstream.
REQ-012 flush  in  1  discard all buffered entries (branch/exception kill).
REQ-013 out_valid  out  1  head entry present.
REQ-014 out_ready  in  1  downstream consumes head this cycle.
REQ-015 out_pc  out  PC_W  head PC.
REQ-016 out_instruction  out  INSTR_W  head instruction.
REQ-017 out_INT  out  1  interrupt flag attached to head.
REQ-018 occupancy  out  2  entry count, 0..2.

Function
REQ-019 Buffer SHALL be a 2-entry in-order skid FIFO, states EMPTY(0), ONE(1), FULL(2); occupancy SHALL equal state.
REQ-020 push = in_valid & in_ready; pop = out_valid & out_ready; evaluated at active edge.
REQ-021 in_ready SHALL be 1 when state != FULL and rst = 0, else 0; it SHALL depend only on state and rst, never combinationally on out_ready.
REQ-022 Transitions: EMPTY+push -> ONE; ONE+push&~pop -> FULL; ONE+pop&~push -> EMPTY; ONE+push&pop -> ONE (new entry becomes head); FULL+pop -> ONE (second entry becomes head); otherwise hold.
REQ-023 Latency SHALL be one active edge: an entry pushed into EMPTY appears on out_* with out_valid = 1 after that edge.
REQ-024 out_valid SHALL be 1 iff state != EMPTY; when EMPTY, out_pc = 0, out_instruction = NOP_INSTR, out_INT = 0.
REQ-025 Head outputs SHALL be stable while out_valid = 1 and out_ready = 0.
REQ-026 flush SHALL set state EMPTY at the active edge, overriding push and pop in the same cycle; the same-cycle input entry SHALL be dropped.
REQ-027 in_INT sampled with in_valid = 0, or with in_ready = 0, SHALL set a sticky pending_INT bit.
REQ-028 A pushed entry SHALL carry out_INT = in_INT | pending_INT; pending_INT SHALL clear on that push.
REQ-029 flush SHALL NOT clear pending_INT; an out_INT belonging to a flushed entry SHALL be moved into pending_INT so no interrupt is lost.
REQ-030 Pushing while FULL SHALL be impossible; upstream holding in_valid with in_ready = 0 SHALL cause no state change.

Reset
REQ-031 rst = 1 SHALL immediately force state EMPTY, pending_INT = 0, out_valid = 0, out_pc = 0, out_instruction = NOP_INSTR, out_INT = 0, in_ready = 0, independent of clk.
REQ-032 Reset asserted mid-transfer SHALL discard all entries; first push SHALL be accepted at the first active edge after rst deasserts.

Structure
REQ-033 Shared package SHALL hold the state enumeration (EMPTY/ONE/FULL), default PC_W/INSTR_W and the default NOP_INSTR constant.
REQ-034 Entry storage SHALL use one sub-module, pipe_entry_reg (PC_W+INSTR_W+1 bits, load enable, async reset, edge per NEG_EDGE), instantiated twice.

Verification
REQ-035 Reset then push pc=0x10, instr=0xDEADBEEF with out_ready=1 -> next edge out_valid=1, out_pc=0x10, out_instruction=0xDEADBEEF, occupancy=1.
REQ-036 out_ready=0, push 0x10, 0x14, 0x18 on consecutive cycles -> occupancy=2, in_ready=0, third push ignored; then out_ready=1 -> heads 0x10, 0x14 in order, then EMPTY.
REQ-037 State ONE with push 0x20 and pop same cycle -> occupancy stays 1, out_pc=0x20.
REQ-038 State FULL, flush=1 with in_valid=1 -> next edge occupancy=0, out_instruction=NOP_INSTR, input dropped.
REQ-039 in_INT=1 with in_valid=0, then push 0x30 -> that entry has out_INT=1, next entry out_INT=0; repeat with a flush between -> out_INT=1 still delivered.
REQ-040 rst pulse between edges while FULL -> outputs reset immediately without a clock edge; run the bench with NEG_EDGE=1 and 0.
